// File: rtl/mem_pkg.sv
// Shared memory-port definitions used by the arbiter and the RAM.
// Latency: none (types, constants and helpers only).
// Backpressure: none.
//
// Contents: access-width codes, Write/Read encoding of the RAM enable line,
// arbiter priority states and a helper that flags unsigned width codes.
package mem_pkg;

  // Access width codes carried on lsu_wid_i / ram_wid_o.
  typedef enum logic [2:0] {
    WID_B    = 3'd0,
    WID_H    = 3'd1,
    WID_W    = 3'd2,
    WID_D    = 3'd3,
    WID_BU   = 3'd4,
    WID_HU   = 3'd5,
    WID_WU   = 3'd6,
    WID_RSVD = 3'd7
  } wid_e;

  // Encoding of the RAM enable-write line: low writes, high reads.
  localparam logic MEM_WRITE = 1'b0;
  localparam logic MEM_READ  = 1'b1;

  // Which requester wins the next conflict.
  typedef enum logic {
    PRIO_LSU = 1'b0,
    PRIO_IF  = 1'b1
  } prio_e;

  // Codes 4..7 (BU, HU, WU and the reserved code) all have bit 2 set. They are
  // meaningful only for loads; a store carrying one of them is illegal.
  function automatic logic wid_is_unsigned(input logic [2:0] wid);
    return wid[2];
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant between the LSU and the instruction fetch.
// Latency: grants are combinational in the request cycle. The priority updates at the next edge.
// Backpressure: the loser of a conflict is simply not granted and must hold its request.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   lsu_req, if_req   requests from the LSU and the fetch unit
//   lsu_gnt, if_gnt   one-hot (or zero) grants, forced low while in reset
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic lsu_req,
  input  logic if_req,
  output logic lsu_gnt,
  output logic if_gnt
);

  prio_e prio_q;
  prio_e prio_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= PRIO_LSU;
    end else begin
      prio_q <= prio_d;
    end
  end

  // A sole requester always wins. Priority only moves when both requesters
  // compete, so an uncontested stream does not steal the next conflict.
  // rst_n gates the grants so nothing reaches the RAM while reset is held.
  always_comb begin
    prio_d  = prio_q;
    lsu_gnt = 1'b0;
    if_gnt  = 1'b0;
    if (rst_n) begin
      if (lsu_req && if_req) begin
        if (prio_q == PRIO_LSU) begin
          lsu_gnt = 1'b1;
          prio_d  = PRIO_IF;
        end else begin
          if_gnt  = 1'b1;
          prio_d  = PRIO_LSU;
        end
      end else begin
        lsu_gnt = lsu_req;
        if_gnt  = if_req;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and the load/store unit.
// Latency: a grant is given in the request cycle. Read data is valid one cycle later. Stores complete at the grant edge.
// Backpressure: there is one grant per cycle. An ungranted requester holds its request until its gnt is seen.
//
// Ports:
//   clk, rst_n                                 clock, asynchronous active-low reset
//   if_req_i/if_addr_i -> if_gnt_o             fetch request, always a WU read
//   if_rvalid_o/if_rdata_o                     fetch response, low 32 bits of the word
//   lsu_req_i/we/addr/wdata/wid -> lsu_gnt_o   load/store request
//   lsu_rvalid_o/lsu_rdata_o                   load response, sign- or zero-extended
//   lsu_err_o                                  one-cycle pulse after a store with an unsigned width code
//   ram_addr_o/ewr_o/data_o/wid_o, ram_data_i  RAM port; the RAM read is combinational
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RAM_SIZE   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [RAM_SIZE-1:0]   if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [31:0]           if_rdata_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [RAM_SIZE-1:0]   lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [2:0]            lsu_wid_i,
  output logic                  lsu_gnt_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_err_o,
  output logic [RAM_SIZE-1:0]   ram_addr_o,
  output logic                  ram_ewr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic [2:0]            ram_wid_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i
);

  // One bundle for everything driven onto the RAM port in a cycle.
  typedef struct packed {
    logic [RAM_SIZE-1:0]   addr;
    logic                  ewr;
    logic [DATA_WIDTH-1:0] data;
    logic [2:0]            wid;
  } ram_cmd_t;

  logic                  if_gnt;
  logic                  lsu_gnt;
  logic                  store_bad;
  logic                  lsu_load_gnt;
  ram_cmd_t              ram_cmd;
  logic [DATA_WIDTH-1:0] load_ext;

  logic                  if_rvalid_q;
  logic [31:0]           if_rdata_q;
  logic                  lsu_rvalid_q;
  logic [DATA_WIDTH-1:0] lsu_rdata_q;
  logic                  lsu_err_q;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .lsu_req (lsu_req_i),
    .if_req  (if_req_i),
    .lsu_gnt (lsu_gnt),
    .if_gnt  (if_gnt)
  );

  // An illegal store is still granted, so the LSU is not stalled forever. The
  // write is suppressed and the error is reported in its place.
  assign store_bad    = lsu_we_i && wid_is_unsigned(lsu_wid_i);
  assign lsu_load_gnt = lsu_gnt && !lsu_we_i;

  // The idle command is a full-width read of address 0. The RAM port
  // therefore never shows a write unless a legal store has been granted.
  always_comb begin
    ram_cmd.addr = '0;
    ram_cmd.ewr  = MEM_READ;
    ram_cmd.data = '0;
    ram_cmd.wid  = WID_D;
    if (lsu_gnt) begin
      ram_cmd.addr = lsu_addr_i;
      ram_cmd.data = lsu_wdata_i;
      ram_cmd.wid  = lsu_wid_i;
      ram_cmd.ewr  = (lsu_we_i && !store_bad) ? MEM_WRITE : MEM_READ;
    end else if (if_gnt) begin
      ram_cmd.addr = if_addr_i;
      ram_cmd.wid  = WID_WU;
    end
  end

  assign ram_addr_o = ram_cmd.addr;
  assign ram_ewr_o  = ram_cmd.ewr;
  assign ram_data_o = ram_cmd.data;
  assign ram_wid_o  = ram_cmd.wid;

  // Loads use the low bytes of the addressed word. Signed codes replicate the
  // top bit of the accessed field. Unsigned codes zero-fill. D and the
  // reserved code pass the whole word through.
  always_comb begin
    load_ext = ram_data_i;
    case (lsu_wid_i)
      WID_B:   load_ext = {{(DATA_WIDTH-8){ram_data_i[7]}},   ram_data_i[7:0]};
      WID_H:   load_ext = {{(DATA_WIDTH-16){ram_data_i[15]}}, ram_data_i[15:0]};
      WID_W:   load_ext = {{(DATA_WIDTH-32){ram_data_i[31]}}, ram_data_i[31:0]};
      WID_BU:  load_ext = {{(DATA_WIDTH-8){1'b0}},  ram_data_i[7:0]};
      WID_HU:  load_ext = {{(DATA_WIDTH-16){1'b0}}, ram_data_i[15:0]};
      WID_WU:  load_ext = {{(DATA_WIDTH-32){1'b0}}, ram_data_i[31:0]};
      default: load_ext = ram_data_i;
    endcase
  end

  // Read data is captured at the end of the grant cycle, while the RAM
  // still presents the granted address. Data registers keep their last value
  // between responses. An asynchronous reset drops any response in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      lsu_rvalid_q <= 1'b0;
      lsu_rdata_q  <= '0;
      lsu_err_q    <= 1'b0;
    end else begin
      if_rvalid_q  <= if_gnt;
      lsu_rvalid_q <= lsu_load_gnt;
      lsu_err_q    <= lsu_gnt && store_bad;
      if (if_gnt) begin
        if_rdata_q <= ram_data_i[31:0];
      end
      if (lsu_load_gnt) begin
        lsu_rdata_q <= load_ext;
      end
    end
  end

  assign if_gnt_o     = if_gnt;
  assign lsu_gnt_o    = lsu_gnt;
  assign if_rvalid_o  = if_rvalid_q;
  assign if_rdata_o   = if_rdata_q;
  assign lsu_rvalid_o = lsu_rvalid_q;
  assign lsu_rdata_o  = lsu_rdata_q;
  assign lsu_err_o    = lsu_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic against a transaction-level model.
// Latency: the bench drives inputs 1 time unit after posedge and samples at negedge.
// Backpressure: the model decides each grant from the round-robin rule and never retries a request.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int DW = 64;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [31:0]   if_rdata_o;
  logic          lsu_req_i = 1'b0;
  logic          lsu_we_i = 1'b0;
  logic [AW-1:0] lsu_addr_i = '0;
  logic [DW-1:0] lsu_wdata_i = '0;
  logic [2:0]    lsu_wid_i = 3'd3;
  logic          lsu_gnt_o;
  logic          lsu_rvalid_o;
  logic [DW-1:0] lsu_rdata_o;
  logic          lsu_err_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_ewr_o;
  logic [DW-1:0] ram_data_o;
  logic [2:0]    ram_wid_o;
  logic [DW-1:0] ram_data_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .RAM_SIZE(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_wid_i    (lsu_wid_i),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .lsu_err_o    (lsu_err_o),
    .ram_addr_o   (ram_addr_o),
    .ram_ewr_o    (ram_ewr_o),
    .ram_data_o   (ram_data_o),
    .ram_wid_o    (ram_wid_o),
    .ram_data_i   (ram_data_i)
  );

  // Bytes touched by an access of a given width code, kept in the low part of the word.
  function automatic logic [63:0] byte_mask(input logic [2:0] wid);
    case (wid)
      3'd0:    return 64'h0000_0000_0000_00FF;
      3'd1:    return 64'h0000_0000_0000_FFFF;
      3'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                        input logic [2:0] wid);
    logic [63:0] m;
    m = byte_mask(wid);
    return (old_w & ~m) | (new_w & m);
  endfunction

  // The RAM attached to the DUT has a combinational read and writes on posedge.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  assign ram_data_i = ram[ram_addr_o];
  always @(posedge clk) begin
    if (ram_ewr_o == MEM_WRITE) ram[ram_addr_o] = merge(ram[ram_addr_o], ram_data_o, ram_wid_o);
  end

  // Reference model, kept at transaction level. It tracks which side wins the
  // next conflict, the memory contents and the response each port should show.
  bit          favour_lsu;
  logic [63:0] model_mem [0:63];
  bit          m_if_vld, m_lsu_vld, m_err;
  logic [31:0] m_if_dat;
  logic [63:0] m_lsu_dat;
  bit          last_if_gnt, last_lsu_gnt;

  function automatic logic [63:0] load_value(input logic [63:0] w, input logic [2:0] wid);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    logic signed [63:0] r;
    sb = w[7:0];
    sh = w[15:0];
    sw = w[31:0];
    case (wid)
      3'd0: r = sb;
      3'd1: r = sh;
      3'd2: r = sw;
      3'd4: r = w & 64'hFF;
      3'd5: r = w & 64'hFFFF;
      3'd6: r = w & 64'hFFFF_FFFF;
      default: r = w;
    endcase
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    favour_lsu = 1'b1;
    m_if_vld   = 1'b0;
    m_lsu_vld  = 1'b0;
    m_err      = 1'b0;
    m_if_dat   = '0;
    m_lsu_dat  = '0;
  endtask

  // Runs one clock cycle. The caller invokes it at posedge+1 and it returns at the next posedge+1.
  task automatic cycle(input bit ireq, input logic [AW-1:0] iaddr, input bit lreq, input bit lwe,
                       input logic [AW-1:0] laddr, input logic [DW-1:0] lwdata,
                       input logic [2:0] lwid);
    bit g_if, g_lsu, bad;
    logic          exp_ewr;
    logic [AW-1:0] exp_addr;
    logic [2:0]    exp_wid;
    logic [DW-1:0] exp_data;
    if_req_i    = ireq;
    if_addr_i   = iaddr;
    lsu_req_i   = lreq;
    lsu_we_i    = lwe;
    lsu_addr_i  = laddr;
    lsu_wdata_i = lwdata;
    lsu_wid_i   = lwid;

    g_lsu = lreq && (!ireq || favour_lsu);
    g_if  = ireq && !g_lsu;
    bad   = lwe && (lwid >= 3'd4);
    exp_ewr  = 1'b1;
    exp_addr = '0;
    exp_wid  = 3'd3;
    exp_data = '0;
    if (g_lsu) begin
      exp_addr = laddr;
      exp_wid  = lwid;
      exp_data = lwdata;
      exp_ewr  = !(lwe && !bad);
    end else if (g_if) begin
      exp_addr = iaddr;
      exp_wid  = 3'd6;
    end

    @(negedge clk);
    check_eq("if_gnt", 64'(if_gnt_o), 64'(g_if));
    check_eq("lsu_gnt", 64'(lsu_gnt_o), 64'(g_lsu));
    check_eq("ram_ewr", 64'(ram_ewr_o), 64'(exp_ewr));
    check_eq("ram_addr", 64'(ram_addr_o), 64'(exp_addr));
    check_eq("ram_wid", 64'(ram_wid_o), 64'(exp_wid));
    if (g_lsu || !g_if) check_eq("ram_data", ram_data_o, exp_data);
    check_eq("if_rvalid", 64'(if_rvalid_o), 64'(m_if_vld));
    check_eq("if_rdata", 64'(if_rdata_o), 64'(m_if_dat));
    check_eq("lsu_rvalid", 64'(lsu_rvalid_o), 64'(m_lsu_vld));
    check_eq("lsu_rdata", lsu_rdata_o, m_lsu_dat);
    check_eq("lsu_err", 64'(lsu_err_o), 64'(m_err));
    last_if_gnt  = if_gnt_o;
    last_lsu_gnt = lsu_gnt_o;

    @(posedge clk);
    if (ireq && lreq) favour_lsu = !g_lsu;
    m_if_vld = g_if;
    if (g_if) m_if_dat = model_mem[iaddr[5:0]][31:0];
    m_lsu_vld = g_lsu && !lwe;
    if (g_lsu && !lwe) m_lsu_dat = load_value(model_mem[laddr[5:0]], lwid);
    m_err = g_lsu && bad;
    if (g_lsu && lwe && !bad) model_mem[laddr[5:0]] = merge(model_mem[laddr[5:0]], lwdata, lwid);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 3'd3);
  endtask

  task automatic mem_compare(input string tag);
    for (int a = 0; a < 64; a++) check_eq(tag, ram[a], model_mem[a]);
  endtask

  initial begin
    model_reset();
    for (int a = 0; a < 64; a++) begin
      model_mem[a] = {$urandom, $urandom};
      ram[a]       = model_mem[a];
    end

    // Hold reset with both requesters active, including a store, to show that nothing is granted.
    if_req_i  = 1'b1;
    lsu_req_i = 1'b1;
    lsu_we_i  = 1'b1;
    lsu_addr_i = 16'h0005;
    lsu_wdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_if_gnt", 64'(if_gnt_o), 64'd0);
      check_eq("rst_lsu_gnt", 64'(lsu_gnt_o), 64'd0);
      check_eq("rst_ewr", 64'(ram_ewr_o), 64'd1);
      check_eq("rst_if_rvalid", 64'(if_rvalid_o), 64'd0);
      check_eq("rst_lsu_rvalid", 64'(lsu_rvalid_o), 64'd0);
      check_eq("rst_err", 64'(lsu_err_o), 64'd0);
      check_eq("rst_if_rdata", 64'(if_rdata_o), 64'd0);
      check_eq("rst_lsu_rdata", lsu_rdata_o, 64'd0);
    end
    if_req_i  = 1'b0;
    lsu_req_i = 1'b0;
    lsu_we_i  = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;

    // Conflicts straight after reset alternate LSU, IF, LSU, IF.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'(i), 1'b1, 1'b0, 16'(32 + i), '0, 3'd3);
      check_eq("rr_lsu_gnt", 64'(last_lsu_gnt), 64'((i % 2) == 0));
      check_eq("rr_if_gnt", 64'(last_if_gnt), 64'((i % 2) == 1));
    end

    // A sole fetch is granted at once and returns the low word one cycle later.
    cycle(1'b0, '0, 1'b1, 1'b1, 16'h0010, 64'h1234_5678_9ABC_DEF0, 3'd3);
    cycle(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, 3'd3);
    check_eq("fetch_gnt", 64'(last_if_gnt), 64'd1);
    check_eq("fetch_rvalid", 64'(if_rvalid_o), 64'd1);
    check_eq("fetch_rdata", 64'(if_rdata_o), 64'h9ABC_DEF0);
    idle();

    // A store is visible to a load in the following cycle; the load is read back sign- and zero-extended.
    cycle(1'b0, '0, 1'b1, 1'b1, 16'h0020, 64'hFFFF_FFFF_FFFF_FF80, 3'd3);
    cycle(1'b0, '0, 1'b1, 1'b0, 16'h0020, '0, 3'd0);
    check_eq("lb_rvalid", 64'(lsu_rvalid_o), 64'd1);
    check_eq("lb_rdata", lsu_rdata_o, 64'hFFFF_FFFF_FFFF_FF80);
    cycle(1'b0, '0, 1'b1, 1'b0, 16'h0020, '0, 3'd4);
    check_eq("lbu_rdata", lsu_rdata_o, 64'h0000_0000_0000_0080);
    idle();
    check_eq("rdata_hold", lsu_rdata_o, 64'h0000_0000_0000_0080);

    // A store with an unsigned width code is granted but writes nothing, and it raises one error pulse.
    cycle(1'b0, '0, 1'b1, 1'b1, 16'h0030, 64'hAAAA_BBBB_CCCC_DDDD, 3'd3);
    cycle(1'b0, '0, 1'b1, 1'b1, 16'h0030, 64'h1111_2222_3333_4444, 3'd5);
    check_eq("hu_store_gnt", 64'(last_lsu_gnt), 64'd1);
    check_eq("hu_store_err", 64'(lsu_err_o), 64'd1);
    check_eq("hu_store_mem", ram[16'h0030], 64'hAAAA_BBBB_CCCC_DDDD);
    idle();
    check_eq("hu_err_once", 64'(lsu_err_o), 64'd0);

    // Ten idle cycles produce no responses and leave memory unchanged.
    repeat (10) idle();
    mem_compare("idle_mem");

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      bit ir, lr, we;
      logic [2:0] w;
      ir = ($urandom_range(0, 3) != 0);
      lr = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) == 1);
      w  = we ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 6));
      cycle(ir, 16'($urandom_range(0, 63)), lr, we, 16'($urandom_range(0, 63)),
            {$urandom, $urandom}, w);
    end
    idle();

    // Reset is asserted at the edge that ends a load grant. The pending response is dropped.
    if_req_i   = 1'b0;
    lsu_req_i  = 1'b1;
    lsu_we_i   = 1'b0;
    lsu_addr_i = 16'h0010;
    lsu_wid_i  = 3'd3;
    @(negedge clk);
    check_eq("rst_ld_gnt", 64'(lsu_gnt_o), 64'd1);
    @(posedge clk);
    rst_n    = 1'b0;
    if_req_i = 1'b1;
    lsu_we_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst2_lsu_rvalid", 64'(lsu_rvalid_o), 64'd0);
      check_eq("rst2_ewr", 64'(ram_ewr_o), 64'd1);
      check_eq("rst2_lsu_gnt", 64'(lsu_gnt_o), 64'd0);
      check_eq("rst2_if_gnt", 64'(if_gnt_o), 64'd0);
      check_eq("rst2_lsu_rdata", lsu_rdata_o, 64'd0);
    end
    if_req_i  = 1'b0;
    lsu_req_i = 1'b0;
    lsu_we_i  = 1'b0;
    rst_n     = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Priority favours the LSU again after reset.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'(i), 1'b1, 1'b0, 16'(8 + i), '0, 3'($urandom_range(0, 6)));
      check_eq("rr2_lsu_gnt", 64'(last_lsu_gnt), 64'((i % 2) == 0));
    end
    idle();
    mem_compare("final_mem");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, RAM word width.
REQ-002 SHALL have parameter RAM_SIZE, default 16, RAM word-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_req_i  input  1  fetch read request.
REQ-006 SHALL have port if_addr_i  input  RAM_SIZE  fetch word address.
REQ-007 SHALL have port if_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_rvalid_o  output  1  fetch data valid.
REQ-009 SHALL have port if_rdata_o  output  32  fetch instruction, zero-extended low word.
REQ-010 SHALL have port lsu_req_i  input  1  load/store request.
REQ-011 SHALL have port lsu_we_i  input  1  1 = store, 0 = load.
REQ-012 SHALL have port lsu_addr_i  input  RAM_SIZE  load/store word address.
REQ-013 SHALL have port lsu_wdata_i  input  DATA_WIDTH  store data.
REQ-014 SHALL have port lsu_wid_i  input  3  access width code: B=0, H=1, W=2, D=3, BU=4, HU=5, WU=6.
REQ-015 SHALL have port lsu_gnt_o  output  1  LSU request accepted this cycle.
REQ-016 SHALL have port lsu_rvalid_o  output  1  load data valid.
REQ-017 SHALL have port lsu_rdata_o  output  DATA_WIDTH  extended load data.
REQ-018 SHALL have port lsu_err_o  output  1  one-cycle pulse: store with unsigned width code.
REQ-019 SHALL have ports ram_addr_o (RAM_SIZE), ram_ewr_o (1; 0 = write, 1 = read), ram_data_o (DATA_WIDTH), ram_wid_o (3), all outputs, and ram_data_i (DATA_WIDTH, input, combinational RAM read data).

Function
REQ-020 SHALL grant at most one requester per cycle; grant is combinational from the requests and the priority register.
REQ-021 SHALL arbitrate round-robin: on conflict, grant the requester not granted last; prio register updates only on a conflicted grant.
REQ-022 SHALL grant a sole requester immediately, regardless of priority.
REQ-023 SHALL drive the granted requester's address, width and data to the RAM port in the grant cycle; fetch uses ram_ewr_o=1, ram_wid_o=WU.
REQ-024 SHALL, with no grant, drive ram_ewr_o=1, ram_wid_o=D, ram_addr_o=0, ram_data_o=0, so no spurious write occurs.
REQ-025 SHALL capture ram_data_i into the response register of the granted read at the grant-cycle edge; rvalid asserts exactly one cycle later for one cycle (latency 1).
REQ-026 SHALL complete stores at the grant-cycle edge, without rvalid.
REQ-027 SHALL, for a store with lsu_wid_i in {BU, HU, WU, 7}, grant, force ram_ewr_o=1 (no write), and pulse lsu_err_o the next cycle.
REQ-028 SHALL sustain back-to-back grants each cycle; response registers hold their last data when rvalid is low.
REQ-029 SHALL make a store in cycle N visible to a load of the same address in cycle N+1.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear if_rvalid_o, lsu_rvalid_o and lsu_err_o, zero both rdata registers, and set prio to favour LSU.
REQ-031 SHALL force both grants to 0 and ram_ewr_o to 1 while rst_n is low; a response pending at reset is dropped.

Structure
REQ-032 SHALL take the width codes and the Write=0/Read=1 encoding from a shared package mem_pkg, also used by the RAM.
REQ-033 SHALL have an optional sub-module rr_arbiter2 (2-way round-robin grant plus prio register); everything else stays flat.

Verification
REQ-034 SHALL have a bench test: if_req only, addr 0x10 holding 0x1234_5678_9ABC_DEF0 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0x9ABC_DEF0.
REQ-035 SHALL have a bench test: both request for 4 cycles, reset prio -> grants LSU, IF, LSU, IF.
REQ-036 SHALL have a bench test: store D 0xFFFF_FFFF_FFFF_FF80 to 0x20, then LB 0x20 next cycle -> lsu_rdata=0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80.
REQ-037 SHALL have a bench test: store with wid=HU to 0x30 -> lsu_gnt=1, RAM word 0x30 unchanged, lsu_err pulses once.
REQ-038 SHALL have a bench test: rst_n low in the cycle after a load grant -> lsu_rvalid stays 0 and ram_ewr_o=1 throughout reset.
REQ-039 SHALL have a bench test: no requests for 10 cycles -> no RAM content changes, no rvalid.
